// File: rtl/stats_arbiter_avlstrm_if.sv
// Stats beat type and the single-beat stream interface used between packers, arbiter and unpacker.
// Latency: none, wires only.
// Backpressure: the sink drives ready; a beat moves on a clock edge where valid && ready.
package stats_pkg;
    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] val;
    } stats_t;
endpackage

interface avl_stream_if;
    import stats_pkg::*;
    logic   valid;
    logic   ready;
    logic   sop;
    logic   eop;
    stats_t data;

    modport rx (input valid, input sop, input eop, input data, output ready);
    modport tx (output valid, output sop, output eop, output data, input ready);
endinterface

// File: rtl/stats_arbiter_avlstrm.sv
// Round-robin merge of NUM_IN single-beat stats streams into one registered stats stream.
// Latency: 1 cycle; a beat accepted at edge N is on stats_out from edge N onward.
// Backpressure: only the granted port sees ready, and only while the output register is empty or draining.
// Optional: define STATS_ARB_ADDR_REMAP_EN to offset each port's addr by port*ADDR_STRIDE.
module stats_arbiter_avlstrm
    import stats_pkg::*;
#(
    parameter int NUM_IN      = 2,
    parameter int ADDR_STRIDE = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    avl_stream_if.rx                 stats_in [NUM_IN],
    avl_stream_if.tx                 stats_out,
    output logic [$clog2(NUM_IN):0]  grant_idx
);

    localparam int PW = $clog2(NUM_IN) + 1;

    // Output stage and arbitration state
    logic          r_out_vld;
    stats_t        r_out_dat;
    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] r_grant_idx;

    localparam int AW = $bits(r_out_dat.addr);

    logic [NUM_IN-1:0] w_in_vld;
    logic [NUM_IN-1:0] w_in_marks;
    stats_t            w_in_dat [NUM_IN];
    logic              w_can_load;
    logic              w_gnt_vld;
    logic [PW-1:0]     w_gnt;
    int                w_idx;
    stats_t            w_mux;
    logic              w_unused;

    // Flatten the interface array; ready is the one-hot grant
    for (genvar i = 0; i < NUM_IN; i++) begin : g_port
        assign w_in_vld[i]        = stats_in[i].valid;
        assign w_in_dat[i]        = stats_in[i].data;
        assign w_in_marks[i]      = stats_in[i].sop ^ stats_in[i].eop;
        assign stats_in[i].ready  = w_gnt_vld && (w_gnt == PW'(i));
    end

    // Every beat is single-beat, so input framing marks carry no information here
`ifdef STATS_ARB_ADDR_REMAP_EN
    assign w_unused = ^w_in_marks;
`else
    assign w_unused = ^{w_in_marks, ADDR_STRIDE[0]};
`endif

    // The output register can take a new beat if it is empty or being drained this cycle
    assign w_can_load = !r_out_vld || stats_out.ready;

    // Search ports from rr_ptr upward with wrap; first valid port wins when a load is possible
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_IN) begin
                w_idx = w_idx - NUM_IN;
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if (!w_gnt_vld && (w_idx == i) && w_in_vld[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = PW'(i);
                end
            end
        end
        if (!w_can_load) begin
            w_gnt_vld = 1'b0;
        end
    end

    // Select the granted port's beat; optionally shift its addr into that port's window
    always_comb begin
        w_mux = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gnt == PW'(i)) begin
                w_mux = w_in_dat[i];
`ifdef STATS_ARB_ADDR_REMAP_EN
                w_mux.addr = w_in_dat[i].addr + AW'(i * ADDR_STRIDE);
`endif
            end
        end
    end

    // Load on grant, drain when the sink takes the beat, hold everything on a stall
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_out_vld   <= 1'b0;
            r_out_dat   <= '0;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
        end else if (w_gnt_vld) begin
            r_out_vld   <= 1'b1;
            r_out_dat   <= w_mux;
            r_grant_idx <= w_gnt;
            r_rr_ptr    <= (w_gnt == PW'(NUM_IN - 1)) ? '0 : (w_gnt + PW'(1));
        end else if (stats_out.ready) begin
            r_out_vld   <= 1'b0;
        end
    end

    assign stats_out.valid = r_out_vld;
    assign stats_out.sop   = r_out_vld;
    assign stats_out.eop   = r_out_vld;
    assign stats_out.data  = r_out_dat;
    assign grant_idx       = r_grant_idx;

endmodule

// File: tb/tb_stats_arbiter_avlstrm.sv
// Bench for stats_arbiter_avlstrm: a NUM_IN=2 and a NUM_IN=3 instance side by side.
// Directed vector table, hand sequences for reset / wrap / single-port cases, then random traffic.
// Random traffic is scored against a plain round-robin model of the arbitration rules.
module tb_stats_arbiter_avlstrm;
    import stats_pkg::*;

    localparam int TB_STRIDE = 16;
`ifdef STATS_ARB_ADDR_REMAP_EN
    localparam int TB_REMAP = 1;
`else
    localparam int TB_REMAP = 0;
`endif

    logic Clk;
    logic Rst_n;

    // Bench-side view of both DUTs; index 0 = NUM_IN=2, index 1 = NUM_IN=3
    logic [2:0] t_vld  [2];
    stats_t     t_dat  [2][3];
    logic       t_ordy [2];
    logic [2:0] t_irdy [2];
    logic       t_ovld [2];
    logic       t_osop [2];
    logic       t_oeop [2];
    stats_t     t_odat [2];
    logic [2:0] t_gidx [2];
    logic [1:0] gidx2;
    logic [2:0] gidx3;

    avl_stream_if s2_in [2] ();
    avl_stream_if s2_out ();
    avl_stream_if s3_in [3] ();
    avl_stream_if s3_out ();

    for (genvar p = 0; p < 2; p++) begin : g_in2
        assign s2_in[p].valid = t_vld[0][p];
        assign s2_in[p].sop   = t_vld[0][p];
        assign s2_in[p].eop   = t_vld[0][p];
        assign s2_in[p].data  = t_dat[0][p];
        assign t_irdy[0][p]   = s2_in[p].ready;
    end
    assign t_irdy[0][2] = 1'b0;

    for (genvar p = 0; p < 3; p++) begin : g_in3
        assign s3_in[p].valid = t_vld[1][p];
        assign s3_in[p].sop   = t_vld[1][p];
        assign s3_in[p].eop   = t_vld[1][p];
        assign s3_in[p].data  = t_dat[1][p];
        assign t_irdy[1][p]   = s3_in[p].ready;
    end

    assign s2_out.ready = t_ordy[0];
    assign s3_out.ready = t_ordy[1];
    assign t_ovld[0] = s2_out.valid;
    assign t_osop[0] = s2_out.sop;
    assign t_oeop[0] = s2_out.eop;
    assign t_odat[0] = s2_out.data;
    assign t_ovld[1] = s3_out.valid;
    assign t_osop[1] = s3_out.sop;
    assign t_oeop[1] = s3_out.eop;
    assign t_odat[1] = s3_out.data;
    assign t_gidx[0] = {1'b0, gidx2};
    assign t_gidx[1] = gidx3;

    stats_arbiter_avlstrm #(.NUM_IN(2), .ADDR_STRIDE(TB_STRIDE)) u_dut2 (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .stats_in  (s2_in),
        .stats_out (s2_out),
        .grant_idx (gidx2)
    );

    stats_arbiter_avlstrm #(.NUM_IN(3), .ADDR_STRIDE(TB_STRIDE)) u_dut3 (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .stats_in  (s3_in),
        .stats_out (s3_out),
        .grant_idx (gidx3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic stats_t mkdat(input int p, input int c);
        stats_t s;
        s.addr = 16'(p * 256 + c);
        s.val  = 32'hA000_0000 + 32'(p * 65536) + 32'(c);
        return s;
    endfunction

    function automatic stats_t remap(input int p, input stats_t s);
        stats_t r;
        r = s;
        r.addr = s.addr + 16'(p * TB_STRIDE * TB_REMAP);
        return r;
    endfunction

    function automatic int nports(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    // Reference model: output register contents plus the port that gets first look next
    logic   m_ovld   [2];
    stats_t m_odat   [2];
    int     m_gidx   [2];
    int     m_ptr    [2];
    int     m_g      [2];
    int     m_last_g [2];

    function automatic int pick(input int d);
        int n;
        int p;
        n = nports(d);
        if (m_ovld[d] && !t_ordy[d]) return -1;
        for (int k = 0; k < n; k++) begin
            p = (m_ptr[d] + k) % n;
            if (t_vld[d][p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ovld[d]   = 1'b0;
            m_odat[d]   = '0;
            m_gidx[d]   = 0;
            m_ptr[d]    = 0;
            m_g[d]      = -1;
            m_last_g[d] = -1;
        end
    endtask

    // One random-phase cycle: compare at the falling edge, advance the model at the rising edge
    task automatic tick();
        @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            m_g[d] = pick(d);
            for (int p = 0; p < nports(d); p++)
                chk($sformatf("rnd_in_ready d%0d p%0d", d, p), 64'(t_irdy[d][p]), 64'(m_g[d] == p));
            chk($sformatf("rnd_out_valid d%0d", d), 64'(t_ovld[d]), 64'(m_ovld[d]));
            chk($sformatf("rnd_sop_eop d%0d", d), 64'({t_osop[d], t_oeop[d]}), 64'({m_ovld[d], m_ovld[d]}));
            chk($sformatf("rnd_grant_idx d%0d", d), 64'(t_gidx[d]), 64'(m_gidx[d]));
            if (m_ovld[d])
                chk($sformatf("rnd_out_data d%0d", d), 64'(t_odat[d]), 64'(m_odat[d]));
        end
        @(posedge Clk);
        for (int d = 0; d < 2; d++) begin
            if (m_g[d] >= 0) begin
                m_ovld[d] = 1'b1;
                m_odat[d] = remap(m_g[d], t_dat[d][m_g[d]]);
                m_gidx[d] = m_g[d];
                m_ptr[d]  = (m_g[d] + 1) % nports(d);
            end else if (t_ordy[d]) begin
                m_ovld[d] = 1'b0;
            end
            m_last_g[d] = m_g[d];
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            t_vld[d]  = '0;
            t_ordy[d] = 1'b1;
            for (int p = 0; p < 3; p++) t_dat[d][p] = '0;
        end
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_valid d%0d", d), 64'(t_ovld[d]), 64'd0);
            chk($sformatf("reset_sop_eop d%0d", d), 64'({t_osop[d], t_oeop[d]}), 64'd0);
            chk($sformatf("reset_data d%0d", d), 64'(t_odat[d]), 64'd0);
            chk($sformatf("reset_grant_idx d%0d", d), 64'(t_gidx[d]), 64'd0);
        end
        Rst_n = 1'b1;
    endtask

    // Directed vectors for the 2-port instance, applied one per cycle straight out of reset
    typedef struct {
        logic [1:0] vld;
        logic       ordy;
        logic [1:0] exp_irdy;
        logic       exp_ovld;
        int         exp_g;
        int         exp_ld;
    } vec_t;

    function automatic vec_t mkv(input logic [1:0] v, input logic r, input logic [1:0] ir,
                                 input logic ov, input int g, input int ld);
        vec_t x;
        x.vld = v; x.ordy = r; x.exp_irdy = ir; x.exp_ovld = ov; x.exp_g = g; x.exp_ld = ld;
        return x;
    endfunction

    vec_t vt [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0;
        idle_inputs();

        vt[0]  = mkv(2'b11, 1'b1, 2'b01, 1'b1, 0, 0);
        vt[1]  = mkv(2'b11, 1'b1, 2'b10, 1'b1, 1, 1);
        vt[2]  = mkv(2'b11, 1'b1, 2'b01, 1'b1, 0, 2);
        vt[3]  = mkv(2'b11, 1'b1, 2'b10, 1'b1, 1, 3);
        vt[4]  = mkv(2'b11, 1'b0, 2'b00, 1'b1, 1, 3);
        vt[5]  = mkv(2'b11, 1'b0, 2'b00, 1'b1, 1, 3);
        vt[6]  = mkv(2'b11, 1'b0, 2'b00, 1'b1, 1, 3);
        vt[7]  = mkv(2'b11, 1'b0, 2'b00, 1'b1, 1, 3);
        vt[8]  = mkv(2'b11, 1'b1, 2'b01, 1'b1, 0, 8);
        vt[9]  = mkv(2'b10, 1'b1, 2'b10, 1'b1, 1, 9);
        vt[10] = mkv(2'b00, 1'b1, 2'b00, 1'b0, 1, 0);
        vt[11] = mkv(2'b10, 1'b0, 2'b10, 1'b1, 1, 11);
        vt[12] = mkv(2'b01, 1'b0, 2'b00, 1'b1, 1, 11);
        vt[13] = mkv(2'b01, 1'b1, 2'b01, 1'b1, 0, 13);
        vt[14] = mkv(2'b00, 1'b0, 2'b00, 1'b1, 0, 13);
        vt[15] = mkv(2'b00, 1'b1, 2'b00, 1'b0, 0, 0);

        do_reset();

        for (int i = 0; i < 16; i++) begin
            t_vld[0]    = {1'b0, vt[i].vld};
            t_ordy[0]   = vt[i].ordy;
            t_dat[0][0] = mkdat(0, i);
            t_dat[0][1] = mkdat(1, i);
            @(negedge Clk);
            chk($sformatf("vec%0d in_ready", i), 64'(t_irdy[0][1:0]), 64'(vt[i].exp_irdy));
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 64'(t_ovld[0]), 64'(vt[i].exp_ovld));
            chk($sformatf("vec%0d sop_eop", i), 64'({t_osop[0], t_oeop[0]}), 64'({vt[i].exp_ovld, vt[i].exp_ovld}));
            chk($sformatf("vec%0d grant_idx", i), 64'(t_gidx[0]), 64'(vt[i].exp_g));
            if (vt[i].exp_ovld)
                chk($sformatf("vec%0d out_data", i), 64'(t_odat[0]),
                    64'(remap(vt[i].exp_g, mkdat(vt[i].exp_g, vt[i].exp_ld))));
        end

        // Only port 1 valid: single beat appears one edge later with framing marks and grant 1
        idle_inputs();
        do_reset();
        t_vld[0]         = 3'b010;
        t_dat[0][1].addr = 16'd5;
        t_dat[0][1].val  = 32'hDEADBEEF;
        @(posedge Clk);
        #1;
        chk("p1only out_valid", 64'(t_ovld[0]), 64'd1);
        chk("p1only sop_eop", 64'({t_osop[0], t_oeop[0]}), 64'b11);
        chk("p1only addr", 64'(t_odat[0].addr), 64'(16'(5 + TB_STRIDE * TB_REMAP)));
        chk("p1only val", 64'(t_odat[0].val), 64'h0000_0000_DEAD_BEEF);
        chk("p1only grant_idx", 64'(t_gidx[0]), 64'd1);
        t_dat[0][1].addr = 16'd3;
        t_dat[0][1].val  = 32'h0000_1234;
        @(posedge Clk);
        #1;
        chk("remap addr3", 64'(t_odat[0].addr), 64'((TB_REMAP == 1) ? 19 : 3));
        chk("remap val", 64'(t_odat[0].val), 64'h1234);
        t_vld[0] = '0;

        // Three ports: after serving port 0, ports 0 and 2 pending -> 2 first, then wrap to 0
        idle_inputs();
        do_reset();
        t_vld[1]    = 3'b001;
        t_dat[1][0] = mkdat(0, 20);
        @(posedge Clk);
        #1;
        chk("wrap first grant", 64'(t_gidx[1]), 64'd0);
        t_vld[1]    = 3'b101;
        t_dat[1][0] = mkdat(0, 21);
        t_dat[1][2] = mkdat(2, 21);
        @(negedge Clk);
        chk("wrap ready p2", 64'(t_irdy[1]), 64'b100);
        @(posedge Clk);
        #1;
        chk("wrap grant p2", 64'(t_gidx[1]), 64'd2);
        chk("wrap data p2", 64'(t_odat[1]), 64'(remap(2, mkdat(2, 21))));
        @(negedge Clk);
        chk("wrap ready p0", 64'(t_irdy[1]), 64'b001);
        @(posedge Clk);
        #1;
        chk("wrap grant p0", 64'(t_gidx[1]), 64'd0);
        chk("wrap data p0", 64'(t_odat[1]), 64'(remap(0, mkdat(0, 21))));
        t_vld[1] = '0;

        // Asynchronous reset while a beat is stalled in the output register
        idle_inputs();
        t_vld[0]    = 3'b011;
        t_ordy[0]   = 1'b0;
        t_dat[0][0] = mkdat(0, 40);
        t_dat[0][1] = mkdat(1, 40);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("arst pre valid", 64'(t_ovld[0]), 64'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst valid", 64'(t_ovld[0]), 64'd0);
        chk("arst sop_eop", 64'({t_osop[0], t_oeop[0]}), 64'd0);
        chk("arst data", 64'(t_odat[0]), 64'd0);
        chk("arst grant_idx", 64'(t_gidx[0]), 64'd0);
        @(posedge Clk);
        #1;
        Rst_n       = 1'b1;
        t_ordy[0]   = 1'b1;
        t_dat[0][0] = mkdat(0, 50);
        t_dat[0][1] = mkdat(1, 50);
        @(negedge Clk);
        chk("arst first ready", 64'(t_irdy[0][1:0]), 64'b01);
        @(posedge Clk);
        #1;
        chk("arst first grant", 64'(t_gidx[0]), 64'd0);
        chk("arst first data", 64'(t_odat[0]), 64'(remap(0, mkdat(0, 50))));

        // Random traffic on both instances against the model; a pending beat holds until taken
        idle_inputs();
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < nports(d); p++) begin
                    if (!t_vld[d][p] || (m_last_g[d] == p)) begin
                        t_vld[d][p]      = ($urandom_range(0, 99) < 55);
                        t_dat[d][p].addr = 16'($urandom());
                        t_dat[d][p].val  = $urandom();
                    end
                    if (c >= 1000 && c < 1100) t_vld[d][p] = 1'b1;
                end
                t_ordy[d] = (c >= 1000 && c < 1100) ? 1'b1 : ($urandom_range(0, 99) < 70);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stats_arbiter_avlstrm.md
Name: stats_arbiter_avlstrm

Overview:
- Merges NUM_IN stats streams into one stats stream. Each input stream comes from a stats packer instance inside a service.
- The single output feeds one stats unpacker / register file.
- Arbitration is round-robin with a single registered output stage. Each stats_t beat (addr, val) passes through as one beat.
- Lets several services share one host-visible stats register file.

Parameters:
- NUM_IN, 2, number of input stats streams (>=1).
- ADDR_STRIDE, 16, per-port address offset step; used only when STATS_ARB_ADDR_REMAP_EN is defined.

Ports:
- Clk  input  1  clock.
- Rst_n  input  1  reset; asynchronous, active-low.
- stats_in[NUM_IN]  avl_stream_if.rx  interface  input stats streams; data carries stats_t.
- stats_out  avl_stream_if.tx  interface  merged stats stream; data carries stats_t.
- grant_idx  output  $clog2(NUM_IN)+1  index of the port last loaded into the output stage (debug).

Behaviour:
- Reset (Rst_n low, asynchronous):
  - stats_out.valid=0, stats_out.sop=0, stats_out.eop=0, stats_out.data=0.
  - rr_ptr=0, grant_idx=0.
- Output stage: one register (out_valid, out_data).
  - stats_out.valid=out_valid.
  - sop and eop equal out_valid, since every beat is single-beat.
- can_load = !out_valid || stats_out.ready. Loading and draining in the same cycle is allowed.
- Grant (combinational):
  - Search ports starting at rr_ptr, ascending, wrapping from NUM_IN-1 to 0.
  - The first port with valid=1 is granted, but only if can_load=1.
  - At most one grant per cycle.
- stats_in[i].ready = (grant==i). ready is combinational from the valids and can_load.
  - No ready is asserted for a port that is not valid.
- On a grant to port g at a rising edge:
  - out_data<=stats_in[g].data (remapped if the feature is on).
  - out_valid<=1, grant_idx<=g.
  - rr_ptr<=(g==NUM_IN-1)?0:g+1.
- No grant and stats_out.ready=1 with out_valid=1: out_valid<=0.
- Stall (out_valid=1, ready=0):
  - out_data is held stable and no input is accepted.
  - rr_ptr and grant_idx are unchanged.
- Latency: an input beat accepted at edge N appears on stats_out from edge N onward (1 cycle, registered).
- Throughput: 1 beat/cycle when stats_out.ready is held at 1.
- Fairness: with all ports continuously valid and the output never stalling, grants are 0,1,...,NUM_IN-1,0,...
  - No port waits more than NUM_IN-1 grants.
- No valid inputs: no grant, rr_ptr holds.
- NUM_IN=1: degenerates to a registered pipe stage; rr_ptr stays 0.
- Reset mid-operation: the pending output beat is discarded. No partial state survives.
  - Upstream packers re-send on their next interval.
- stats_in data is never inspected except for addr remap; val passes through unchanged.

Optional Feature:
- Macro STATS_ARB_ADDR_REMAP_EN.
- Defined: the output addr = in.addr + g*ADDR_STRIDE, truncated to the stats_t addr width (wraps modulo 2^width). This lets identical service instances share one register file without address collisions.
- Undefined: addr passes through unmodified; ADDR_STRIDE is ignored.

Test Plan:
- Reset check: Rst_n low mid-stream with out_valid=1 -> stats_out.valid=0 immediately (asynchronous); after release, the first grant goes to port 0.
- NUM_IN=2, both ports always valid, ready=1 -> output order p0,p1,p0,p1; each ready pulses every other cycle; 1 beat/cycle.
- Only port 1 valid, addr=5, val=0xDEADBEEF -> output beat addr=5 val=0xDEADBEEF one edge later, sop=eop=1, grant_idx=1.
- Output stall: ready=0 for 4 cycles with both ports valid -> data held stable and both stats_in.ready=0. When ready returns, the held beat drains and the next port is loaded in the same cycle.
- NUM_IN=3, ports 0 and 2 valid, rr_ptr=1 -> port 2 is granted first, then port 0 (wrap-around).
- With STATS_ARB_ADDR_REMAP_EN, ADDR_STRIDE=16, port 1 addr=3 -> output addr=19. Without the macro -> output addr=3.
